keypad_scanner: RTL and testbench

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_pkg.sv | 29 ++
 rtl/pulse_generator.sv | 29 ++
 rtl/keypad_scanner.sv | 175 +++++++++++++++++
 tb/tb_keypad_scanner.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Keypad scanner package: FSM state type, 4x4 keymap table, matrix size constants
// and a helper that picks the lowest active (low) row of a row sample.
package keypad_pkg;

    localparam int unsigned ROWS = 4;
    localparam int unsigned COLS = 4;

    typedef enum logic [1:0] {
        StScan,
        StDebounce,
        StHeld,
        StRelease
    } state_t;

    // KEYMAP[row][col] = hex code printed on that key.
    // r0: 1 2 3 A, r1: 4 5 6 B, r2: 7 8 9 C, r3: 0 F E D
    localparam logic [ROWS-1:0][COLS-1:0][3:0] KEYMAP = 64'hDEF0_C987_B654_A321;

    // Index of the lowest-numbered row that is low; 0 when none are low.
    function automatic logic [1:0] lowest_low(input logic [ROWS-1:0] r);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = ROWS - 1; i >= 0; i--) begin
            if (!r[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/pulse_generator.sv
// Periodic strobe: pulse is high for one clk cycle out of every flag cycles,
// on the last cycle of each period (first pulse flag-1 cycles after reset).
// Ports: clk - clock; reset - asynchronous active-low reset; pulse - strobe out.
module pulse_generator #(
    parameter int unsigned flag = 100
) (
    input  logic clk,
    input  logic reset,
    output logic pulse
);

    localparam int unsigned CW = (flag > 1) ? $clog2(flag) : 1;
    localparam logic [CW-1:0] LAST = CW'(flag - 1);

    logic [CW-1:0] count_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else if (count_q == LAST) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + 1'b1;
        end
    end

    assign pulse = (count_q == LAST);

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with debounce and a 4-digit history shift register.
// Columns are driven active-low one at a time; rows (active-low, pulled up) are
// synchronized and sampled once per scan tick. A key is accepted after
// DEBOUNCE_SCANS matching samples and released after DEBOUNCE_SCANS all-high samples.
// Optional feature: define KEYPAD_AUTOREPEAT_EN to re-emit a held key every
// REPEAT_SCANS ticks.
// Ports:
//   clk       - system clock
//   reset     - asynchronous active-low reset
//   row[3:0]  - keypad rows, active-low, asynchronous
//   clear     - synchronous clear of digits (wins over a same-cycle shift)
//   col[3:0]  - column drive, active-low one-hot
//   key_code  - hex code of the last accepted key
//   key_valid - one-cycle pulse per accepted key
//   digits    - last four keys, newest in [3:0]
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_TICKS     = 100_000,
    parameter int unsigned DEBOUNCE_SCANS = 4,
    parameter int unsigned REPEAT_SCANS   = 500
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  row,
    input  logic        clear,
    output logic [3:0]  col,
    output logic [3:0]  key_code,
    output logic        key_valid,
    output logic [15:0] digits
);

    // One counter serves both debounce and repeat intervals.
    localparam int unsigned CNT_MAX = (DEBOUNCE_SCANS > REPEAT_SCANS) ? DEBOUNCE_SCANS
                                                                       : REPEAT_SCANS;
    localparam int unsigned CNT_W = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DEB_N   = CNT_W'(DEBOUNCE_SCANS);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
`ifdef KEYPAD_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] RPT_N = CNT_W'(REPEAT_SCANS);
`endif

    logic [3:0]       row_meta, row_sync;
    logic             tick;
    state_t           state_q, state_d;
    logic [1:0]       col_idx_q, col_idx_d;
    logic [1:0]       row_idx_q, row_idx_d;
    logic [CNT_W-1:0] count_q, count_d, count_inc;
    logic [3:0]       key_code_q, key_code_d;
    logic             key_valid_q, key_valid_d;
    logic [15:0]      digits_q, digits_d;
    logic             all_high, accept;
    logic [1:0]       low_idx;

    pulse_generator #(
        .flag (SCAN_TICKS)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .pulse (tick)
    );

    // Synchronizer resets to the idle (released) level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_meta <= 4'hF;
            row_sync <= 4'hF;
        end else begin
            row_meta <= row;
            row_sync <= row_meta;
        end
    end

    assign all_high  = &row_sync;
    assign low_idx   = lowest_low(row_sync);
    assign count_inc = (&count_q) ? count_q : count_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        col_idx_d   = col_idx_q;
        row_idx_d   = row_idx_q;
        count_d     = count_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        digits_d    = digits_q;
        accept      = 1'b0;
        if (tick) begin
            unique case (state_q)
                StScan: begin
                    if (all_high) begin
                        col_idx_d = col_idx_q + 2'd1;
                    end else begin
                        row_idx_d = low_idx;
                        count_d   = CNT_ONE;
                        state_d   = StDebounce;
                    end
                end
                StDebounce: begin
                    if (!all_high && low_idx == row_idx_q) begin
                        count_d = count_inc;
                        if (count_inc >= DEB_N) begin
                            state_d = StHeld;
                            count_d = '0;
                            accept  = 1'b1;
                        end
                    end else begin
                        state_d   = StScan;
                        col_idx_d = col_idx_q + 2'd1;
                    end
                end
                StHeld: begin
                    if (all_high) begin
                        state_d = StRelease;
                        count_d = CNT_ONE;
                    end
`ifdef KEYPAD_AUTOREPEAT_EN
                    else begin
                        count_d = count_inc;
                        if (count_inc >= RPT_N) begin
                            count_d = '0;
                            accept  = 1'b1;
                        end
                    end
`endif
                end
                StRelease: begin
                    if (all_high) begin
                        count_d = count_inc;
                        if (count_inc >= DEB_N) begin
                            state_d   = StScan;
                            col_idx_d = col_idx_q + 2'd1;
                        end
                    end else begin
                        // Bounce during release: back to held, no new key.
                        state_d = StHeld;
                        count_d = '0;
                    end
                end
                default: state_d = StScan;
            endcase
        end
        if (accept) begin
            key_valid_d = 1'b1;
            key_code_d  = KEYMAP[row_idx_q][col_idx_q];
            digits_d    = {digits_q[11:0], key_code_d};
        end
        if (clear) digits_d = '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StScan;
            col_idx_q   <= 2'd0;
            row_idx_q   <= 2'd0;
            count_q     <= '0;
            key_code_q  <= 4'h0;
            key_valid_q <= 1'b0;
            digits_q    <= 16'h0;
        end else begin
            state_q     <= state_d;
            col_idx_q   <= col_idx_d;
            row_idx_q   <= row_idx_d;
            count_q     <= count_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            digits_q    <= digits_d;
        end
    end

    assign col       = ~(4'b0001 << col_idx_q);
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign digits    = digits_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner with a physical keypad model (a pressed
// key pulls its row low only while its column is driven) and a per-press
// reference model: a press held H ticks yields a pulse if H >= DEBOUNCE_SCANS,
// plus (with auto-repeat) one more per REPEAT_SCANS further held ticks.
`timescale 1ns/1ps
module tb_keypad_scanner;

    localparam int ST   = 4;
    localparam int DB   = 3;
    localparam int RP   = 5;
    localparam int TICK = ST;
`ifdef KEYPAD_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  row;
    logic        clear;
    logic [3:0]  col;
    logic [3:0]  key_code;
    logic        key_valid;
    logic [15:0] digits;

    logic        key_down = 1'b0;
    logic [1:0]  key_r = 2'd0;
    logic [1:0]  key_c = 2'd0;
    logic        force_en = 1'b0;
    logic [3:0]  force_row = 4'hF;
    logic [3:0]  keypad_row;

    int checks = 0;
    int failures = 0;
    int pulse_count = 0;
    int cyc = 0;
    int pulse_cyc[$];
    logic [15:0] digits_model = 16'h0;

    // Spec keymap, indexed row*4 + col.
    logic [3:0] kmap [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                              4'h4, 4'h5, 4'h6, 4'hB,
                              4'h7, 4'h8, 4'h9, 4'hC,
                              4'h0, 4'hF, 4'hE, 4'hD};

    keypad_scanner #(
        .SCAN_TICKS     (ST),
        .DEBOUNCE_SCANS (DB),
        .REPEAT_SCANS   (RP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .row       (row),
        .clear     (clear),
        .col       (col),
        .key_code  (key_code),
        .key_valid (key_valid),
        .digits    (digits)
    );

    always #5 clk = ~clk;

    always_comb begin
        keypad_row = 4'hF;
        if (key_down && !col[key_c]) keypad_row[key_r] = 1'b0;
    end
    assign row = force_en ? force_row : keypad_row;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset && key_valid) begin
            pulse_count <= pulse_count + 1;
            pulse_cyc.push_back(cyc);
        end
    end

    function automatic logic [3:0] col_of(input int c);
        logic [3:0] oh;
        oh = 4'b0001 << c;
        return ~oh;
    endfunction

    function automatic int key_of(input logic [3:0] code);
        int k;
        k = 0;
        for (int i = 0; i < 16; i++) if (kmap[i] == code) k = i;
        return k;
    endfunction

    // Returns at the negedge just after col switches to column c.
    task automatic wait_col(input int c, output bit ok);
        logic [3:0] target, prev;
        target = col_of(c);
        prev = col;
        ok = 1'b0;
        for (int i = 0; i < 80 && !ok; i++) begin
            @(negedge clk);
            if (col == target && prev != target) ok = 1'b1;
            prev = col;
        end
    endtask

    task automatic press(input int k, input int hold, input int rel);
        bit ok;
        int n0, exp_p, exp_c;
        wait_col(k % 4, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL wait_col key=%0d actual col=%b required col=%b", k, col, col_of(k % 4));
        end
        n0 = pulse_count;
        key_r = 2'(k / 4);
        key_c = 2'(k % 4);
        key_down = 1'b1;
        repeat (TICK * hold) @(posedge clk);
        @(negedge clk);
        key_down = 1'b0;
        repeat (TICK * rel) @(posedge clk);
        @(negedge clk);
        exp_p = (hold >= DB) ? 1 + (AR ? (hold - DB) / RP : 0) : 0;
        exp_c = (hold >= DB) ? (k % 4 + 1 + rel - DB) % 4 : (k % 4 + rel) % 4;
        for (int i = 0; i < exp_p; i++) digits_model = {digits_model[11:0], kmap[k]};
        checks++;
        if (pulse_count - n0 != exp_p) begin
            failures++;
            $display("FAIL pulses key=%0d hold=%0d actual=%0d required=%0d",
                     k, hold, pulse_count - n0, exp_p);
        end
        if (exp_p > 0) begin
            checks++;
            if (key_code !== kmap[k]) begin
                failures++;
                $display("FAIL key_code actual=%h required=%h", key_code, kmap[k]);
            end
        end
        checks++;
        if (digits !== digits_model) begin
            failures++;
            $display("FAIL digits key=%0d actual=%h required=%h", k, digits, digits_model);
        end
        checks++;
        if (col !== col_of(exp_c)) begin
            failures++;
            $display("FAIL col_after_release key=%0d actual=%b required=%b",
                     k, col, col_of(exp_c));
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        clear = 1'b0;
        key_down = 1'b0;
        force_en = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (col !== 4'b1110) begin
            failures++; $display("FAIL reset_col actual=%b required=1110", col);
        end
        checks++;
        if (key_code !== 4'h0) begin
            failures++; $display("FAIL reset_key_code actual=%h required=0", key_code);
        end
        checks++;
        if (key_valid !== 1'b0) begin
            failures++; $display("FAIL reset_key_valid actual=%b required=0", key_valid);
        end
        checks++;
        if (digits !== 16'h0) begin
            failures++; $display("FAIL reset_digits actual=%h required=0000", digits);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Starts right at reset release: col index = (cycles / SCAN_TICKS) mod 4.
    task automatic test_idle_scan();
        for (int n = 1; n <= 20 * TICK; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (n % TICK == 2) begin
                checks++;
                if (col !== col_of((n / TICK) % 4)) begin
                    failures++;
                    $display("FAIL idle_col n=%0d actual=%b required=%b",
                             n, col, col_of((n / TICK) % 4));
                end
            end
        end
        checks++;
        if (pulse_count != 0) begin
            failures++; $display("FAIL idle_pulses actual=%0d required=0", pulse_count);
        end
    endtask

    task automatic test_single_key();
        press(key_of(4'h6), 4, 3);
        checks++;
        if (digits !== 16'h0006) begin
            failures++; $display("FAIL single_digits actual=%h required=0006", digits);
        end
    endtask

    task automatic test_sequence();
        logic [3:0] seq [5] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'hF};
        int n0;
        n0 = pulse_count;
        for (int i = 0; i < 5; i++) begin
            press(key_of(seq[i]), int'($urandom_range(3, 7)), int'($urandom_range(3, 5)));
        end
        checks++;
        if (digits !== 16'h23AF) begin
            failures++; $display("FAIL sequence_digits actual=%h required=23af", digits);
        end
        checks++;
        if (pulse_count - n0 != 5) begin
            failures++;
            $display("FAIL sequence_pulses actual=%0d required=5", pulse_count - n0);
        end
    endtask

    task automatic test_bounce();
        int n0;
        logic [3:0] c0, exp_col;
        n0 = pulse_count;
        force_row = 4'hF;
        force_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            force_row = 4'b1110;
            repeat (TICK) @(negedge clk);
            force_row = 4'hF;
            repeat (TICK) @(negedge clk);
        end
        force_en = 1'b0;
        checks++;
        if (pulse_count != n0) begin
            failures++; $display("FAIL bounce_pulses actual=%0d required=0", pulse_count - n0);
        end
        for (int i = 0; i < 2; i++) begin
            c0 = col;
            exp_col = {c0[2:0], c0[3]};
            repeat (TICK) @(negedge clk);
            checks++;
            if (col !== exp_col) begin
                failures++;
                $display("FAIL bounce_rescan actual=%b required=%b", col, exp_col);
            end
        end
    endtask

    task automatic test_clear();
        bit ok;
        int n0;
        wait_col(2, ok);
        checks++;
        if (!ok) begin
            failures++; $display("FAIL clear_wait_col actual=%b required=1011", col);
        end
        n0 = pulse_count;
        key_r = 2'd2;
        key_c = 2'd2;
        key_down = 1'b1;
        repeat (DB * TICK - 1) @(posedge clk);
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clear = 1'b0;
        digits_model = 16'h0;
        checks++;
        if (key_valid !== 1'b1) begin
            failures++; $display("FAIL clear_key_valid actual=%b required=1", key_valid);
        end
        checks++;
        if (key_code !== 4'h9) begin
            failures++; $display("FAIL clear_key_code actual=%h required=9", key_code);
        end
        checks++;
        if (digits !== 16'h0) begin
            failures++; $display("FAIL clear_digits actual=%h required=0000", digits);
        end
        repeat (TICK) @(posedge clk);
        @(negedge clk);
        key_down = 1'b0;
        repeat (TICK * 3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (pulse_count - n0 != 1) begin
            failures++; $display("FAIL clear_pulses actual=%0d required=1", pulse_count - n0);
        end
    endtask

    task automatic test_random_keys();
        int k;
        for (int i = 0; i < 10; i++) begin
            k = int'($urandom_range(0, 15));
            press(k, int'($urandom_range(1, 9)), int'($urandom_range(3, 5)));
        end
    endtask

    task automatic test_autorepeat();
        int n0;
        n0 = pulse_cyc.size();
        press(key_of(4'h5), 14, 3);
`ifdef KEYPAD_AUTOREPEAT_EN
        checks++;
        if (pulse_cyc.size() < n0 + 3) begin
            failures++;
            $display("FAIL repeat_count actual=%0d required=3", pulse_cyc.size() - n0);
        end else begin
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (pulse_cyc[n0 + i + 1] - pulse_cyc[n0 + i] != RP * TICK) begin
                    failures++;
                    $display("FAIL repeat_spacing actual=%0d required=%0d",
                             pulse_cyc[n0 + i + 1] - pulse_cyc[n0 + i], RP * TICK);
                end
            end
        end
`else
        checks++;
        if (pulse_cyc.size() - n0 != 1) begin
            failures++;
            $display("FAIL no_repeat_count actual=%0d required=1", pulse_cyc.size() - n0);
        end
`endif
    endtask

    task automatic test_reset_mid();
        bit ok;
        int n0;
        wait_col(1, ok);
        checks++;
        if (!ok) begin
            failures++; $display("FAIL rmid_wait_col actual=%b required=1101", col);
        end
        key_r = 2'd1;
        key_c = 2'd1;
        key_down = 1'b1;
        repeat (TICK + 2) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        checks++;
        if (col !== 4'b1110) begin
            failures++; $display("FAIL rmid_col actual=%b required=1110", col);
        end
        checks++;
        if (key_code !== 4'h0) begin
            failures++; $display("FAIL rmid_key_code actual=%h required=0", key_code);
        end
        checks++;
        if (key_valid !== 1'b0) begin
            failures++; $display("FAIL rmid_key_valid actual=%b required=0", key_valid);
        end
        checks++;
        if (digits !== 16'h0) begin
            failures++; $display("FAIL rmid_digits actual=%h required=0000", digits);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        digits_model = 16'h0;
        n0 = pulse_count;
        // Still held: column 1 comes round after one dwell, then a full debounce.
        repeat (TICK * (DB + 1) - 1) @(posedge clk);
        @(negedge clk);
        checks++;
        if (key_valid !== 1'b0 || pulse_count != n0) begin
            failures++;
            $display("FAIL rmid_early actual=%b/%0d required=0/0", key_valid, pulse_count - n0);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (key_valid !== 1'b1) begin
            failures++; $display("FAIL rmid_accept actual=%b required=1", key_valid);
        end
        checks++;
        if (key_code !== 4'h5) begin
            failures++; $display("FAIL rmid_key_code_new actual=%h required=5", key_code);
        end
        digits_model = {digits_model[11:0], 4'h5};
        key_down = 1'b0;
        repeat (TICK * 3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (digits !== digits_model) begin
            failures++;
            $display("FAIL rmid_digits_new actual=%h required=%h", digits, digits_model);
        end
        checks++;
        if (pulse_count - n0 != 1) begin
            failures++; $display("FAIL rmid_pulses actual=%0d required=1", pulse_count - n0);
        end
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_idle_scan();
        test_single_key();
        test_sequence();
        test_bounce();
        test_clear();
        test_random_keys();
        test_autorepeat();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
